// File: rtl/clock_reset_sequencer_pkg.sv
// Shared state encoding and default timing constants for the PLL/DCM clock/reset sequencer.
// No logic; imported by the sequencer and its interface.
package clock_reset_pkg;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 4;
    localparam int DEF_STAT_WIDTH    = 8;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// Sequencer <-> clock controller / system reset signals; master = sequencer side.
// lock_loss_count exists only when LOCK_STATS_EN is defined.
interface clock_reset_sequencer_if #(
    parameter int MAX_RETRIES = clock_reset_pkg::DEF_MAX_RETRIES
`ifdef LOCK_STATS_EN
    , parameter int STAT_WIDTH = clock_reset_pkg::DEF_STAT_WIDTH
`endif
);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          locked;
    logic          clk_ctl_rst;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_count;
`ifdef LOCK_STATS_EN
    logic [STAT_WIDTH-1:0] lock_loss_count;
`endif

    modport master (
        input  locked,
        output clk_ctl_rst,
        output ready,
        output fault,
        output retry_count
`ifdef LOCK_STATS_EN
        , output lock_loss_count
`endif
    );

    modport slave (
        output locked,
        input  clk_ctl_rst,
        input  ready,
        input  fault,
        input  retry_count
`ifdef LOCK_STATS_EN
        , input lock_loss_count
`endif
    );

endinterface

// File: rtl/clock_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single async level; 2-cycle latency, no backpressure.
// Both flops reset low so an async input reads as deasserted straight out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_reset_sequencer.sv
// Pulses the clock controller reset, qualifies lock with timeout/retry, publishes ready/fault.
// Outputs registered; lock seen 2 cycles late via sync_2ff; optional LOCK_STATS_EN adds lock_loss_count.
module clock_reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
`ifdef LOCK_STATS_EN
    , parameter int STAT_WIDTH  = DEF_STAT_WIDTH
`endif
) (
    input logic clk,
    input logic rst,
    clock_reset_sequencer_if.master bus
);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT);
    localparam int SW  = $clog2(STABLE_CYCLES + 1);
    localparam int RW  = $clog2(MAX_RETRIES + 1);

    localparam logic [RCW-1:0] RST_LAST     = RCW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0]  STABLE_DONE  = SW'(STABLE_CYCLES);
    localparam logic [RW-1:0]  RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t         state;
    logic [RCW-1:0] rst_cnt;
    logic [TW-1:0]  timer;
    logic [SW-1:0]  stable_cnt;
    logic [RW-1:0]  retry_cnt;
    logic           clk_ctl_rst_q;
    logic           ready_q;
    logic           fault_q;
    logic           locked_s;

    logic [SW-1:0]  stable_nxt;
    logic [RW-1:0]  retry_nxt;
    logic           timeout;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.locked),
        .q   (locked_s)
    );

    // The cycle that first sees lock already counts as one stable cycle.
    assign stable_nxt = (state == S_WAIT_LOCK) ? SW'(1) : stable_cnt + SW'(1);
    assign retry_nxt  = retry_cnt + RW'(1);
    assign timeout    = (timer == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RESET;
            rst_cnt       <= '0;
            timer         <= '0;
            stable_cnt    <= '0;
            retry_cnt     <= '0;
            clk_ctl_rst_q <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state         <= S_WAIT_LOCK;
                        clk_ctl_rst_q <= 1'b0;
                        timer         <= '0;
                        rst_cnt       <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    timer <= timer + TW'(1);
                    // Timeout is checked first so it beats a same-cycle qualification.
                    if (timeout) begin
                        timer         <= '0;
                        retry_cnt     <= retry_nxt;
                        clk_ctl_rst_q <= 1'b1;
                        if (retry_nxt == RETRY_LIMIT) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state   <= S_RESET;
                            rst_cnt <= '0;
                        end
                    end else if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                    end else if (stable_nxt == STABLE_DONE) begin
                        state     <= S_RUN;
                        ready_q   <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        state      <= S_STABLE;
                        stable_cnt <= stable_nxt;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state         <= S_RESET;
                        ready_q       <= 1'b0;
                        clk_ctl_rst_q <= 1'b1;
                        rst_cnt       <= '0;
                    end
                end
                S_FAULT: begin
                    clk_ctl_rst_q <= 1'b1;
                    ready_q       <= 1'b0;
                    fault_q       <= 1'b1;
                end
                default: begin
                    state         <= S_RESET;
                    rst_cnt       <= '0;
                    clk_ctl_rst_q <= 1'b1;
                    ready_q       <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOCK_STATS_EN
    logic [STAT_WIDTH-1:0] loss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if (state == S_RUN && !locked_s && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + STAT_WIDTH'(1);
        end
    end

    assign bus.lock_loss_count = loss_cnt;
`endif

    assign bus.clk_ctl_rst = clk_ctl_rst_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_cnt;

endmodule
